// File: rtl/apb_initiator.sv
// APB initiator: turns one command-channel request into a single APB transfer
// and returns its completion (read data, slave error, timeout) on a response channel.
module apb_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateType;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the ACCESS cycle whose stall would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    stateType         state;
    stateType         nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             timeoutHit;

    assign timeoutHit = (TIMEOUT > 0) && (state == ACCESS) && !PREADY && (waitCnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= nextState;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (cmd_valid)            nextState = SETUP;
            SETUP:                             nextState = ACCESS;
            ACCESS:  if (PREADY || timeoutHit) nextState = RESP;
            RESP:    if (rsp_ready)            nextState = IDLE;
            default:                           nextState = IDLE;
        endcase
    end

    // Handshake and APB strobes decode from the state register only; reset masks cmd_ready.
    always_comb begin
        cmd_ready = (state == IDLE) && !PRESET;
        PSEL      = (state == SETUP) || (state == ACCESS);
        PENABLE   = (state == ACCESS);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            waitCnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SETUP: waitCnt <= '0;
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if (timeoutHit) begin
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
